// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory port arbiter.
// Owner encoding doubles as the read-return tag.
package dmem_arb_pkg;

   typedef enum logic [1:0] {OWN_IDLE, OWN_C, OWN_H} owner_t;

   localparam int MAX_BURST_DFLT = 4;
   localparam int BEAT_CNT_W     = $clog2(MAX_BURST_DFLT);

   // Counter width that still works when MAX_BURST is 1 or 2
   function automatic int beatCntWidth(input int maxBurst);
      return (maxBurst > 2) ? $clog2(maxBurst) : 1;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: resolves ties with a pointer that moves to
// the other requester whenever a burst is released.
module rr_pick2 (
   input  logic clk,
   input  logic reset,
   input  logic req_c_i,
   input  logic req_h_i,
   input  logic release_i,
   input  logic rel_from_c_i,
   output logic pick_c_o,
   output logic pick_h_o
);

   logic ptrH_q;
   logic ptrH_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptrH_q <= 1'b0;
      end else begin
         ptrH_q <= ptrH_d;
      end
   end

   always_comb begin
      ptrH_d = ptrH_q;
      if (release_i) begin
         ptrH_d = rel_from_c_i;
      end
   end

   assign pick_c_o = req_c_i & (~req_h_i | ~ptrH_q);
   assign pick_h_o = req_h_i & (~req_c_i |  ptrH_q);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data-memory port between the core (C) and the host
// bridge (H) with burst-locked, round-robin ownership and 1-cycle read return.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = MAX_BURST_DFLT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic              c_last,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              h_req,
   input  logic              h_we,
   input  logic              h_last,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_gnt,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              burst_overrun
);

   localparam int              CNT_W    = beatCntWidth(MAX_BURST);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   owner_t           state_q, state_d;
   owner_t           rdTag_q, rdTag_d;
   logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
   logic             overrun_q, overrun_d;

   logic ownC, ownH;
   logic selReq, selWe, selLast, otherReq;
   logic accept, relBurst, pickC, pickH;

   assign ownC = (state_q == OWN_C);
   assign ownH = (state_q == OWN_H);

   always_comb begin
      selReq   = ownC ? c_req  : (ownH ? h_req  : 1'b0);
      selWe    = ownC ? c_we   : (ownH ? h_we   : 1'b0);
      selLast  = ownC ? c_last : (ownH ? h_last : 1'b0);
      otherReq = ownC ? h_req  : c_req;
   end

   // Nothing reaches memory while reset is held, even if a burst was open
   assign accept   = selReq & ~reset;
   assign relBurst = accept & (selLast | (beatCnt_q == LAST_CNT));

   assign mem_addr  = ownH ? h_addr  : c_addr;
   assign mem_wdata = ownH ? h_wdata : c_wdata;
   assign mem_we    = accept &  selWe;
   assign mem_re    = accept & ~selWe;

   rr_pick2 u_pick (
      .clk          (clk),
      .reset        (reset),
      .req_c_i      (c_req),
      .req_h_i      (h_req),
      .release_i    (relBurst),
      .rel_from_c_i (ownC),
      .pick_c_o     (pickC),
      .pick_h_o     (pickH)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= OWN_IDLE;
         rdTag_q   <= OWN_IDLE;
         beatCnt_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rdTag_q   <= rdTag_d;
         beatCnt_q <= beatCnt_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rdTag_d   = OWN_IDLE;
      beatCnt_d = beatCnt_q;
      overrun_d = 1'b0;
      if (accept) begin
         rdTag_d   = selWe ? OWN_IDLE : state_q;
         beatCnt_d = beatCnt_q + 1'b1;
      end
      case (state_q)
         OWN_IDLE: begin
            if (pickC) begin
               state_d = OWN_C;
            end else if (pickH) begin
               state_d = OWN_H;
            end
         end
         default: begin
            // Handoff skips the bubble when the other side is already waiting
            if (relBurst) begin
               beatCnt_d = '0;
               overrun_d = ~selLast;
               if (otherReq) begin
                  state_d = ownC ? OWN_H : OWN_C;
               end else begin
                  state_d = OWN_IDLE;
               end
            end
         end
      endcase
   end

   assign c_gnt         = ownC & ~reset;
   assign h_gnt         = ownH & ~reset;
   assign c_rvalid      = (rdTag_q == OWN_C) & ~reset;
   assign h_rvalid      = (rdTag_q == OWN_H) & ~reset;
   assign c_rdata       = mem_rdata;
   assign h_rdata       = mem_rdata;
   assign burst_overrun = overrun_q & ~reset;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a per-cycle
// ownership/burst model with its own copy of memory contents.
module tb_dmem_port_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, c_last, h_req, h_we, h_last;
   logic [31:0] c_addr, c_wdata, h_addr, h_wdata;
   logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
   logic [31:0] c_rdata, h_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re, burst_overrun;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_last(c_last), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .h_req(h_req), .h_we(h_we), .h_last(h_last), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .burst_overrun(burst_overrun)
   );

   function automatic logic [31:0] seedWord(input int idx);
      return (idx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Bench memory: 1-cycle read latency, unwritten words read a seed pattern
   logic [31:0] memArr [256];
   bit          memVld [256];
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= memVld[mem_addr[9:2]] ? memArr[mem_addr[9:2]] : seedWord(int'(mem_addr[9:2]));
      if (mem_we) begin
         memArr[mem_addr[9:2]] <= mem_wdata;
         memVld[mem_addr[9:2]] <= 1'b1;
      end
   end

   int nChecks = 0;
   int nFails  = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Requester scripts: index 0 = core, 1 = host
   bit          gActive [2];
   bit          gWe [2];
   int          gLen [2], gBeat [2], gBase [2], gGapBeat [2], gGapLeft [2], gGapPct [2];
   bit          reqNow [2], lastNow [2];
   logic [31:0] addrNow [2], wdNow [2];
   int          autoMode = 0;

   // Reference model state: owner 0 none, 1 core, 2 host; ptr 0 favours core
   int          mOwner, mBeats, mPtr;
   bit          mOverrun, mPend;
   int          mPendOwner;
   logic [31:0] mPendData;
   logic [31:0] refMem [256];
   bit          refVld [256];

   int cRvCnt, hRvCnt, ovCnt, cGntCyc, hGntCyc;

   task automatic startBurst(input int r, input int len, input bit we, input int base,
                             input int gapBeat, input int gapLen);
      gActive[r]  = 1'b1;
      gLen[r]     = len;
      gBeat[r]    = 0;
      gWe[r]      = we;
      gBase[r]    = base;
      gGapBeat[r] = gapBeat;
      gGapLeft[r] = gapLen;
      gGapPct[r]  = 0;
   endtask

   task automatic applyStimulus(input bit rst);
      bit idle;
      for (int r = 0; r < 2; r++) begin
         if (!gActive[r]) begin
            if (autoMode == 1) begin
               startBurst(r, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) << 2, 0, 0);
            end else if (autoMode == 2 && $urandom_range(0, 99) < 30) begin
               startBurst(r, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 240)) << 2, int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 2)));
               gGapPct[r] = 15;
            end
         end
         idle = 1'b0;
         if (gGapLeft[r] > 0 && gBeat[r] == gGapBeat[r]) begin
            idle = 1'b1;
            gGapLeft[r]--;
         end else if (int'($urandom_range(0, 99)) < gGapPct[r]) begin
            idle = 1'b1;
         end
         reqNow[r]  = gActive[r] && !idle;
         lastNow[r] = (gBeat[r] == gLen[r] - 1);
         addrNow[r] = 32'(gBase[r] + gBeat[r] * 4);
         wdNow[r]   = $urandom;
      end
      reset   = rst;
      c_req   = reqNow[0]; c_we = gWe[0]; c_last = lastNow[0]; c_addr = addrNow[0]; c_wdata = wdNow[0];
      h_req   = reqNow[1]; h_we = gWe[1]; h_last = lastNow[1]; h_addr = addrNow[1]; h_wdata = wdNow[1];
   endtask

   // One cycle: drive, compare against the model, then advance model and scripts
   task automatic step(input bit rst);
      int  r, o, idx;
      bit  acc, newPend;
      applyStimulus(rst);
      #1;
      cRvCnt  += int'(c_rvalid);
      hRvCnt  += int'(h_rvalid);
      ovCnt   += int'(burst_overrun);
      cGntCyc += int'(c_gnt);
      hGntCyc += int'(h_gnt);
      if (rst) begin
         checkOutput("rstGnt", {c_gnt, h_gnt}, 2'b00);
         checkOutput("rstStrobe", {mem_we, mem_re}, 2'b00);
         checkOutput("rstRvalid", {c_rvalid, h_rvalid}, 2'b00);
         checkOutput("rstOverrun", burst_overrun, 1'b0);
         mOwner = 0; mBeats = 0; mPtr = 0; mOverrun = 0; mPend = 0;
      end else begin
         checkOutput("gnt", {c_gnt, h_gnt}, {mOwner == 1, mOwner == 2});
         checkOutput("rvalid", {c_rvalid, h_rvalid}, {mPend && mPendOwner == 1, mPend && mPendOwner == 2});
         if (mPend) checkOutput("rdata", (mPendOwner == 1) ? c_rdata : h_rdata, mPendData);
         checkOutput("overrun", burst_overrun, mOverrun);
         r   = mOwner - 1;
         acc = (mOwner != 0) && reqNow[r];
         checkOutput("strobes", {mem_we, mem_re}, {acc && gWe[r], acc && !gWe[r]});
         if (acc) begin
            checkOutput("memAddr", mem_addr, addrNow[r]);
            if (gWe[r]) checkOutput("memWdata", mem_wdata, wdNow[r]);
         end
         mOverrun = 0;
         newPend  = 0;
         if (acc) begin
            idx = int'(addrNow[r][9:2]);
            if (gWe[r]) begin
               refMem[idx] = wdNow[r];
               refVld[idx] = 1'b1;
            end else begin
               newPend    = 1;
               mPendOwner = mOwner;
               mPendData  = refVld[idx] ? refMem[idx] : seedWord(idx);
            end
            gBeat[r]++;
            if (gBeat[r] == gLen[r]) gActive[r] = 1'b0;
            mBeats++;
            if (lastNow[r] || mBeats == MAXB) begin
               o        = 1 - r;
               mPtr     = o;
               mOverrun = !lastNow[r];
               mBeats   = 0;
               mOwner   = reqNow[o] ? o + 1 : 0;
            end
         end else if (mOwner == 0) begin
            if (reqNow[0] && reqNow[1]) mOwner = mPtr + 1;
            else if (reqNow[0])         mOwner = 1;
            else if (reqNow[1])         mOwner = 2;
         end
         mPend = newPend;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      gActive[0] = 1'b0;
      gActive[1] = 1'b0;
      step(1'b1);
      step(1'b1);
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      autoMode = 0;
      while ((gActive[0] || gActive[1] || mOwner != 0 || mPend) && n < limit) begin
         step(1'b0);
         n++;
      end
      if (n >= limit) checkOutput("idleTimeout", 1'b0, 1'b1);
   endtask

   task automatic clearCounts();
      cRvCnt = 0; hRvCnt = 0; ovCnt = 0; cGntCyc = 0; hGntCyc = 0;
   endtask

   initial begin
      int singles, toggles;
      bit prevC;
      for (int i = 0; i < 2; i++) begin
         gActive[i] = 0; gLen[i] = 1; gBeat[i] = 0; gWe[i] = 0; gBase[i] = 0;
         gGapBeat[i] = 0; gGapLeft[i] = 0; gGapPct[i] = 0;
      end
      clearCounts();
      @(posedge clk);
      #1;
      doReset();

      $display("[TB] single core read");
      startBurst(0, 1, 1'b0, 32'h100, 0, 0);
      waitIdle(20);

      $display("[TB] tie: core 4-beat write, host 1-beat read");
      doReset();
      clearCounts();
      startBurst(0, 4, 1'b1, 32'h200, 0, 0);
      startBurst(1, 1, 1'b0, 32'h40, 0, 0);
      waitIdle(20);
      checkOutput("t2CoreGntCycles", cGntCyc, 4);
      checkOutput("t2HostGntCycles", hGntCyc, 1);
      checkOutput("t2HostReads", hRvCnt, 1);

      $display("[TB] core vector read with a gap");
      clearCounts();
      startBurst(0, 4, 1'b0, 32'h200, 2, 2);
      waitIdle(30);
      checkOutput("t3CoreRvalids", cRvCnt, 4);
      checkOutput("t3GntHeld", cGntCyc, 6);

      $display("[TB] host 5-beat burst");
      clearCounts();
      startBurst(1, 5, 1'b1, 32'h380, 0, 0);
      waitIdle(30);
      checkOutput("t4Overruns", ovCnt, 1);
      checkOutput("t4HostGntCycles", hGntCyc, 5);

      $display("[TB] reset during read return");
      startBurst(0, 1, 1'b0, 32'h140, 0, 0);
      step(1'b0);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      startBurst(0, 1, 1'b0, 32'h144, 0, 0);
      startBurst(1, 1, 1'b0, 32'h148, 0, 0);
      step(1'b0);
      checkOutput("t5PostRstTieCore", {c_gnt, h_gnt}, 2'b10);
      waitIdle(20);

      $display("[TB] back-to-back alternating singles");
      autoMode = 1;
      step(1'b0);
      step(1'b0);
      singles = 0; toggles = 0; prevC = c_gnt;
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         singles += int'(c_gnt ^ h_gnt);
         toggles += int'(c_gnt != prevC);
         prevC = c_gnt;
      end
      checkOutput("t6SingleGrant", singles, 10);
      checkOutput("t6Alternate", toggles, 10);
      waitIdle(30);

      $display("[TB] randomized traffic");
      autoMode = 2;
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0);
      end
      waitIdle(200);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
